// File: rtl/verinject_check_pkg.sv
// Shared types and helpers for the lockstep checker: FSM encoding, lowest-set-bit and saturating increment.
//  state       | meaning
//  ST_IDLE     | waiting for arm, statistics held
//  ST_ARMED    | run active, no divergence seen yet
//  ST_DIVERGED | at least one divergence, counting clean samples
//  ST_SETTLED  | outputs reconverged after a divergence
//  ST_HALTED   | frozen at first divergence (STOP_ON_FIRST)
package verinject_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_DIVERGED = 3'd2,
        ST_SETTLED  = 3'd3,
        ST_HALTED   = 3'd4
    } state_e;

    localparam int unsigned LSB_MAX_W = 256;
    localparam int unsigned SAT_MAX_W = 64;

    function automatic int unsigned lowest_set(input logic [LSB_MAX_W-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = LSB_MAX_W - 1; i >= 0; i--) begin
            if (v[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

    // Counter of width w held in the low bits of a wide vector; sticks at all-ones.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                     input int unsigned w);
        logic [SAT_MAX_W-1:0] maxv;
        maxv = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
        return (v == maxv) ? v : v + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/verinject_lane_compare.sv
// One channel of the lockstep compare: masked word inequality, registered as a stage-1 mismatch bit.
module verinject_lane_compare
    import verinject_check_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_real,
    input  logic [WIDTH-1:0] i_inj,
    input  logic             i_mask,
    output logic             o_mismatch
);

    logic w_diff;
    logic r_mismatch;

    assign w_diff = i_valid && (i_real != i_inj) && !i_mask;

    always_ff @(posedge clock) begin
        if (!reset_n || i_flush) r_mismatch <= 1'b0;
        else                     r_mismatch <= w_diff;
    end

    assign o_mismatch = r_mismatch;

endmodule

// File: rtl/verinject_lockstep_checker.sv
// Lockstep comparator for fault-injection runs: classifies a run as diverged, reconverged or halted
// and records first-divergence cycle, channel, detection latency and a saturating mismatch count.
module verinject_lockstep_checker
    import verinject_check_pkg::*;
#(
    parameter int unsigned  NUM_CHANNELS  = 2,
    parameter int unsigned  WIDTH         = 32,
    parameter int unsigned  CNT_W         = 16,
    parameter int unsigned  CYCLE_W       = 48,
    parameter int unsigned  RECONV_CYCLES = 4,
    parameter bit           STOP_ON_FIRST = 1'b0,
    localparam int unsigned FC_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          arm,
    input  logic                          clear,
    input  logic                          sample_valid,
    input  logic [NUM_CHANNELS*WIDTH-1:0] real_data,
    input  logic [NUM_CHANNELS*WIDTH-1:0] inj_data,
    input  logic [NUM_CHANNELS-1:0]       channel_mask,
    input  logic [CYCLE_W-1:0]            cycle_number,
    output logic [2:0]                    state,
    output logic [NUM_CHANNELS-1:0]       mismatch_now,
    output logic [NUM_CHANNELS-1:0]       sticky,
    output logic [CYCLE_W-1:0]            first_cycle,
    output logic [FC_W-1:0]               first_channel,
    output logic [CNT_W-1:0]              mismatch_count,
    output logic [CNT_W-1:0]              detect_latency,
    output logic                          reconverged,
    output logic                          halted
);

    localparam logic [CNT_W-1:0] RECONV_V = CNT_W'(RECONV_CYCLES);

    logic [NUM_CHANNELS-1:0] w_s1_mis;
    logic                    r_s1_valid;
    logic [CYCLE_W-1:0]      r_s1_cycle;
    logic                    w_divergent;
    logic                    w_clean;
    logic [CNT_W-1:0]        w_clean_next;

    state_e                  r_state;
    state_e                  w_state_next;

    logic [NUM_CHANNELS-1:0] r_sticky;
    logic [CYCLE_W-1:0]      r_first_cycle;
    logic [FC_W-1:0]         r_first_channel;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        r_latency;
    logic [CNT_W-1:0]        r_clean;
    logic                    r_reconv;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
        verinject_lane_compare #(.WIDTH(WIDTH)) u_lane (
            .clock      (clock),
            .reset_n    (reset_n),
            .i_flush    (clear),
            .i_valid    (sample_valid),
            .i_real     (real_data[c*WIDTH +: WIDTH]),
            .i_inj      (inj_data[c*WIDTH +: WIDTH]),
            .i_mask     (channel_mask[c]),
            .o_mismatch (w_s1_mis[c])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            r_s1_valid <= 1'b0;
            r_s1_cycle <= '0;
        end else begin
            r_s1_valid <= sample_valid;
            r_s1_cycle <= cycle_number;
        end
    end

    assign w_divergent  = r_s1_valid && (|w_s1_mis);
    assign w_clean      = r_s1_valid && !(|w_s1_mis);
    assign w_clean_next = r_clean + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (!reset_n || clear) r_state <= ST_IDLE;
        else                   r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (arm) begin
            w_state_next = ST_ARMED;
        end else begin
            case (r_state)
                ST_IDLE:     w_state_next = ST_IDLE;
                ST_ARMED:    if (w_divergent) w_state_next = STOP_ON_FIRST ? ST_HALTED : ST_DIVERGED;
                ST_DIVERGED: if (w_clean && (w_clean_next == RECONV_V)) w_state_next = ST_SETTLED;
                ST_SETTLED:  if (w_divergent) w_state_next = ST_DIVERGED;
                ST_HALTED:   w_state_next = ST_HALTED;
                default:     w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        state  = r_state;
        halted = (r_state == ST_HALTED);
    end

    // arm discards whatever divergence sits in stage 1 on that edge.
    always_ff @(posedge clock) begin
        if (!reset_n || clear || arm) begin
            r_sticky        <= '0;
            r_first_cycle   <= '0;
            r_first_channel <= '0;
            r_count         <= '0;
            r_latency       <= '0;
            r_clean         <= '0;
            r_reconv        <= 1'b0;
        end else begin
            r_reconv <= (r_state == ST_DIVERGED) && (w_state_next == ST_SETTLED);
            case (r_state)
                ST_ARMED: begin
                    if (w_divergent) begin
                        r_first_cycle   <= r_s1_cycle;
                        r_first_channel <= FC_W'(lowest_set(LSB_MAX_W'(w_s1_mis)));
                        r_sticky        <= r_sticky | w_s1_mis;
                        r_count         <= CNT_W'(1);
                        r_clean         <= '0;
                    end else begin
                        r_latency <= CNT_W'(sat_inc(SAT_MAX_W'(r_latency), CNT_W));
                    end
                end
                ST_DIVERGED, ST_SETTLED: begin
                    if (w_divergent) begin
                        r_count  <= CNT_W'(sat_inc(SAT_MAX_W'(r_count), CNT_W));
                        r_sticky <= r_sticky | w_s1_mis;
                        r_clean  <= '0;
                    end else if (w_clean && (r_state == ST_DIVERGED)) begin
                        r_clean <= w_clean_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mismatch_now   = w_s1_mis;
    assign sticky         = r_sticky;
    assign first_cycle    = r_first_cycle;
    assign first_channel  = r_first_channel;
    assign mismatch_count = r_count;
    assign detect_latency = r_latency;
    assign reconverged    = r_reconv;

endmodule

// File: tb/tb_verinject_lockstep_checker.sv
// Directed bench for the lockstep checker: default, stop-on-first and 4-bit-counter instances share one stimulus.
module tb_verinject_lockstep_checker;

    logic        clock = 1'b0;
    logic        reset_n, arm, clear, sample_valid;
    logic [63:0] real_data, inj_data;
    logic [1:0]  channel_mask;
    logic [47:0] cycle_number;

    logic [2:0]  m_state, s_state, t_state;
    logic [1:0]  m_now, s_now, t_now, m_sticky, s_sticky, t_sticky;
    logic [47:0] m_fcyc, s_fcyc, t_fcyc;
    logic        m_fch, s_fch, t_fch;
    logic [15:0] m_count, s_count, m_lat, s_lat;
    logic [3:0]  t_count, t_lat;
    logic        m_reconv, s_reconv, t_reconv, m_halted, s_halted, t_halted;

    int n_pass  = 0;
    int n_total = 0;
    int pulses;

    always #5 clock = ~clock;

    verinject_lockstep_checker u_main (
        .clock(clock), .reset_n(reset_n), .arm(arm), .clear(clear), .sample_valid(sample_valid),
        .real_data(real_data), .inj_data(inj_data), .channel_mask(channel_mask), .cycle_number(cycle_number),
        .state(m_state), .mismatch_now(m_now), .sticky(m_sticky), .first_cycle(m_fcyc), .first_channel(m_fch),
        .mismatch_count(m_count), .detect_latency(m_lat), .reconverged(m_reconv), .halted(m_halted));

    verinject_lockstep_checker #(.STOP_ON_FIRST(1'b1)) u_stop (
        .clock(clock), .reset_n(reset_n), .arm(arm), .clear(clear), .sample_valid(sample_valid),
        .real_data(real_data), .inj_data(inj_data), .channel_mask(channel_mask), .cycle_number(cycle_number),
        .state(s_state), .mismatch_now(s_now), .sticky(s_sticky), .first_cycle(s_fcyc), .first_channel(s_fch),
        .mismatch_count(s_count), .detect_latency(s_lat), .reconverged(s_reconv), .halted(s_halted));

    verinject_lockstep_checker #(.CNT_W(4)) u_sat (
        .clock(clock), .reset_n(reset_n), .arm(arm), .clear(clear), .sample_valid(sample_valid),
        .real_data(real_data), .inj_data(inj_data), .channel_mask(channel_mask), .cycle_number(cycle_number),
        .state(t_state), .mismatch_now(t_now), .sticky(t_sticky), .first_cycle(t_fcyc), .first_channel(t_fch),
        .mismatch_count(t_count), .detect_latency(t_lat), .reconverged(t_reconv), .halted(t_halted));

    // After step() the bench sits 1 ns past edge N and cycle_number == N.
    task automatic step();
        @(posedge clock);
        #1;
        cycle_number = cycle_number + 48'd1;
    endtask

    task automatic eq_data();
        real_data = {$urandom, $urandom};
        inj_data  = real_data;
    endtask

    task automatic run_to(input logic [47:0] k);
        while (cycle_number < k) begin
            eq_data();
            step();
        end
    endtask

    task automatic clear_run();
        clear = 1'b1;
        eq_data();
        step();
        clear = 1'b0;
    endtask

    task automatic arm_now();
        arm = 1'b1;
        eq_data();
        step();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; arm = 1'b0; clear = 1'b0; sample_valid = 1'b1;
        channel_mask = 2'b00; cycle_number = '0;
        eq_data();
        inj_data = ~real_data;
        step();
        step();
        n_total++; if (m_state !== 3'd0) $display("FAIL rst_state got=%0d exp=0", m_state); else n_pass++;
        n_total++; if (m_now !== 2'b00) $display("FAIL rst_mismatch_now got=%b exp=00", m_now); else n_pass++;
        n_total++; if (m_sticky !== 2'b00) $display("FAIL rst_sticky got=%b exp=00", m_sticky); else n_pass++;
        n_total++; if (m_fcyc !== 48'd0) $display("FAIL rst_first_cycle got=%0d exp=0", m_fcyc); else n_pass++;
        n_total++; if (m_count !== 16'd0) $display("FAIL rst_count got=%0d exp=0", m_count); else n_pass++;
        n_total++; if (m_lat !== 16'd0) $display("FAIL rst_latency got=%0d exp=0", m_lat); else n_pass++;
        n_total++; if (m_reconv !== 1'b0 || m_halted !== 1'b0 || m_fch !== 1'b0)
            $display("FAIL rst_flags got=%b%b%b exp=000", m_reconv, m_halted, m_fch); else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_equal_streams();
        clear_run();
        cycle_number = 48'd5;
        arm_now();
        repeat (100) begin
            eq_data();
            step();
        end
        n_total++; if (m_state !== 3'd1) $display("FAIL eq_state got=%0d exp=1", m_state); else n_pass++;
        n_total++; if (m_count !== 16'd0) $display("FAIL eq_count got=%0d exp=0", m_count); else n_pass++;
        n_total++; if (m_sticky !== 2'b00) $display("FAIL eq_sticky got=%b exp=00", m_sticky); else n_pass++;
        n_total++; if (m_lat !== 16'd100) $display("FAIL eq_latency got=%0d exp=100", m_lat); else n_pass++;
    endtask

    task automatic test_diverge_reconverge();
        clear_run();
        cycle_number = 48'd10;
        arm_now();
        run_to(48'd30);
        eq_data();
        inj_data[35] = ~inj_data[35];
        step();
        n_total++; if (m_now !== 2'b10) $display("FAIL div_mismatch_now got=%b exp=10", m_now); else n_pass++;
        eq_data();
        step();
        n_total++; if (m_state !== 3'd2) $display("FAIL div_state got=%0d exp=2", m_state); else n_pass++;
        n_total++; if (m_fcyc !== 48'd30) $display("FAIL div_first_cycle got=%0d exp=30", m_fcyc); else n_pass++;
        n_total++; if (m_fch !== 1'b1) $display("FAIL div_first_channel got=%0d exp=1", m_fch); else n_pass++;
        n_total++; if (m_lat !== 16'd20) $display("FAIL div_latency got=%0d exp=20", m_lat); else n_pass++;
        n_total++; if (m_count !== 16'd1) $display("FAIL div_count got=%0d exp=1", m_count); else n_pass++;
        n_total++; if (m_sticky !== 2'b10) $display("FAIL div_sticky got=%b exp=10", m_sticky); else n_pass++;
        pulses = 0;
        repeat (5) begin
            eq_data();
            step();
            if (m_reconv === 1'b1) pulses++;
        end
        n_total++; if (pulses != 1) $display("FAIL reconv_pulses got=%0d exp=1", pulses); else n_pass++;
        n_total++; if (m_state !== 3'd3) $display("FAIL reconv_state got=%0d exp=3", m_state); else n_pass++;
        run_to(48'd40);
        eq_data();
        inj_data[7] = ~inj_data[7];
        step();
        eq_data();
        step();
        n_total++; if (m_state !== 3'd2) $display("FAIL rediv_state got=%0d exp=2", m_state); else n_pass++;
        n_total++; if (m_count !== 16'd2) $display("FAIL rediv_count got=%0d exp=2", m_count); else n_pass++;
        n_total++; if (m_fcyc !== 48'd30 || m_fch !== 1'b1)
            $display("FAIL rediv_first got=%0d/%0d exp=30/1", m_fcyc, m_fch); else n_pass++;
        n_total++; if (m_sticky !== 2'b11) $display("FAIL rediv_sticky got=%b exp=11", m_sticky); else n_pass++;
    endtask

    task automatic test_stop_on_first();
        clear_run();
        cycle_number = 48'd20;
        arm_now();
        run_to(48'd40);
        repeat (6) begin
            eq_data();
            inj_data = ~real_data;
            step();
        end
        n_total++; if (s_state !== 3'd4 || s_halted !== 1'b1)
            $display("FAIL stop_halted got=%0d/%b exp=4/1", s_state, s_halted); else n_pass++;
        n_total++; if (s_fch !== 1'b0) $display("FAIL stop_first_channel got=%0d exp=0", s_fch); else n_pass++;
        n_total++; if (s_fcyc !== 48'd40) $display("FAIL stop_first_cycle got=%0d exp=40", s_fcyc); else n_pass++;
        n_total++; if (s_count !== 16'd1) $display("FAIL stop_count got=%0d exp=1", s_count); else n_pass++;
        n_total++; if (s_lat !== 16'd20) $display("FAIL stop_latency got=%0d exp=20", s_lat); else n_pass++;
        n_total++; if (s_sticky !== 2'b11) $display("FAIL stop_sticky got=%b exp=11", s_sticky); else n_pass++;
        eq_data();
        step();
        eq_data();
        step();
        n_total++; if (m_count !== 16'd6) $display("FAIL nostop_count got=%0d exp=6", m_count); else n_pass++;
        n_total++; if (m_state !== 3'd2) $display("FAIL nostop_state got=%0d exp=2", m_state); else n_pass++;
        arm_now();
        n_total++; if (s_state !== 3'd1 || s_halted !== 1'b0)
            $display("FAIL rearm_state got=%0d/%b exp=1/0", s_state, s_halted); else n_pass++;
        n_total++; if (s_count !== 16'd0 || s_sticky !== 2'b00 || s_fcyc !== 48'd0)
            $display("FAIL rearm_stats got=%0d/%b/%0d exp=0/00/0", s_count, s_sticky, s_fcyc); else n_pass++;
    endtask

    task automatic test_mask_and_clear();
        clear_run();
        channel_mask = 2'b01;
        arm_now();
        repeat (6) begin
            eq_data();
            inj_data[0] = ~inj_data[0];
            step();
        end
        n_total++; if (m_state !== 3'd1) $display("FAIL mask_state got=%0d exp=1", m_state); else n_pass++;
        n_total++; if (m_count !== 16'd0 || m_sticky !== 2'b00 || m_now !== 2'b00)
            $display("FAIL mask_stats got=%0d/%b/%b exp=0/00/00", m_count, m_sticky, m_now); else n_pass++;
        channel_mask = 2'b00;
        eq_data();
        inj_data[0] = ~inj_data[0];
        step();
        eq_data();
        step();
        n_total++; if (m_state !== 3'd2 || m_count !== 16'd1 || m_sticky !== 2'b01 || m_fch !== 1'b0)
            $display("FAIL unmask got=%0d/%0d/%b/%0d exp=2/1/01/0", m_state, m_count, m_sticky, m_fch); else n_pass++;
        clear = 1'b1;
        arm   = 1'b1;
        eq_data();
        inj_data = ~real_data;
        step();
        clear = 1'b0;
        arm   = 1'b0;
        n_total++; if (m_state !== 3'd0) $display("FAIL clrarm_state got=%0d exp=0", m_state); else n_pass++;
        n_total++; if (m_count !== 16'd0 || m_sticky !== 2'b00 || m_lat !== 16'd0 || m_fcyc !== 48'd0)
            $display("FAIL clrarm_stats got=%0d/%b/%0d/%0d exp=0/00/0/0", m_count, m_sticky, m_lat, m_fcyc); else n_pass++;
        n_total++; if (m_now !== 2'b00) $display("FAIL clrarm_flush got=%b exp=00", m_now); else n_pass++;
        eq_data();
        inj_data = ~real_data;
        step();
        n_total++; if (m_now !== 2'b11) $display("FAIL idle_stage got=%b exp=11", m_now); else n_pass++;
        eq_data();
        step();
        n_total++; if (m_state !== 3'd0 || m_count !== 16'd0 || m_sticky !== 2'b00)
            $display("FAIL idle_stats got=%0d/%0d/%b exp=0/0/00", m_state, m_count, m_sticky); else n_pass++;
    endtask

    task automatic test_back_to_back_arm();
        clear_run();
        arm_now();
        eq_data();
        inj_data = ~real_data;
        step();
        eq_data();
        step();
        eq_data();
        inj_data = ~real_data;
        step();
        arm_now();
        n_total++; if (m_state !== 3'd1 || m_count !== 16'd0 || m_sticky !== 2'b00)
            $display("FAIL b2b_arm got=%0d/%0d/%b exp=1/0/00", m_state, m_count, m_sticky); else n_pass++;
        eq_data();
        step();
        n_total++; if (m_state !== 3'd1 || m_count !== 16'd0)
            $display("FAIL b2b_discard got=%0d/%0d exp=1/0", m_state, m_count); else n_pass++;
    endtask

    task automatic test_saturate_and_reset();
        clear_run();
        arm_now();
        repeat (20) begin
            eq_data();
            inj_data = ~real_data;
            step();
        end
        eq_data();
        step();
        eq_data();
        step();
        n_total++; if (t_count !== 4'd15) $display("FAIL sat_count got=%0d exp=15", t_count); else n_pass++;
        n_total++; if (t_state !== 3'd2) $display("FAIL sat_state got=%0d exp=2", t_state); else n_pass++;
        n_total++; if (m_count !== 16'd20) $display("FAIL wide_count got=%0d exp=20", m_count); else n_pass++;
        reset_n = 1'b0;
        eq_data();
        inj_data = ~real_data;
        step();
        n_total++; if (m_state !== 3'd0 || m_count !== 16'd0 || m_sticky !== 2'b00 || m_now !== 2'b00)
            $display("FAIL midrst_main got=%0d/%0d/%b/%b exp=0/0/00/00", m_state, m_count, m_sticky, m_now); else n_pass++;
        n_total++; if (m_fcyc !== 48'd0 || m_lat !== 16'd0 || t_count !== 4'd0 || t_state !== 3'd0)
            $display("FAIL midrst_other got=%0d/%0d/%0d/%0d exp=0/0/0/0", m_fcyc, m_lat, t_count, t_state); else n_pass++;
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_equal_streams();
        test_diverge_reconverge();
        test_stop_on_first();
        test_mask_and_clear();
        test_back_to_back_arm();
        test_saturate_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/verinject_lockstep_checker.md
Name: verinject_lockstep_checker

Overview:
- Synthesizable, parametrised lockstep comparator for fault-injection campaigns.
- Compares NUM_CHANNELS output words of a golden DUT against its `__injected` twin and classifies each run as diverged, reconverged (fault masked late) or halted.
- Records first-divergence cycle, channel and detection latency, and keeps a saturating mismatch count.
- Sits beside verinject_sim_monitor, fed by its cycle_number, so one bench or FPGA harness checks any DUT width or channel count.

Parameters:
- NUM_CHANNELS, 2, number of compared output words.
- WIDTH, 32, bits per channel.
- CNT_W, 16, width of mismatch_count and detect_latency; both saturate at all-ones.
- CYCLE_W, 48, width of cycle_number and first_cycle.
- RECONV_CYCLES, 4, consecutive clean valid samples needed to declare reconvergence; legal range 1..2^CNT_W-1.
- STOP_ON_FIRST, 0; 1 = freeze in HALTED at first divergence.

Ports:
- clock  in  1  sole clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- arm  in  1  single-cycle pulse that starts a checking run.
- clear  in  1  synchronous clear of all statistics; state returns to IDLE.
- sample_valid  in  1  real_data and inj_data are comparable this cycle.
- real_data  in  NUM_CHANNELS*WIDTH  golden outputs, channel c at bits [c*WIDTH +: WIDTH].
- inj_data  in  NUM_CHANNELS*WIDTH  injected-DUT outputs, same packing.
- channel_mask  in  NUM_CHANNELS  1 = channel ignored.
- cycle_number  in  CYCLE_W  free-running cycle count from the injection monitor.
- state  out  3  FSM state encoding.
- mismatch_now  out  NUM_CHANNELS  registered per-channel unmasked mismatch of the previous valid sample.
- sticky  out  NUM_CHANNELS  per-channel OR of mismatch_now since arm.
- first_cycle  out  CYCLE_W  cycle_number of the first divergent sample.
- first_channel  out  $clog2(NUM_CHANNELS) (min 1)  lowest-index mismatching channel of that sample.
- mismatch_count  out  CNT_W  number of divergent samples since arm.
- detect_latency  out  CNT_W  cycles from arm to the first divergent sample.
- reconverged  out  1  one-cycle pulse on entering SETTLED.
- halted  out  1  high while in HALTED.

Behaviour:
- Reset (reset_n=0 at an edge): every output 0; state=IDLE (0); internal counters 0.
- States: IDLE=0, ARMED=1, DIVERGED=2, SETTLED=3, HALTED=4.
- Stage 1 registers sample_valid, per-channel (real != inj) & ~channel_mask, and cycle_number. The FSM acts on stage 1, so a sample presented in cycle k affects outputs after edge k+1; mismatch_now shows this stage directly.
- A sample is "divergent" when its stage-1 copy is valid and has any mismatch bit set.
- Stage 1 loads every cycle, including IDLE. A divergent sample presented in the same cycle as arm acts on the cycle after arm; arm does not suppress it.
- IDLE: arm -> ARMED, detect_latency=0. Stage-1 samples do not update statistics.
- ARMED:
  - detect_latency increments once per cycle, saturating.
  - First divergent sample: capture first_cycle from the stage-1 cycle copy and first_channel as the lowest set bit, OR sticky, mismatch_count=1. Go to HALTED if STOP_ON_FIRST, else DIVERGED.
- DIVERGED:
  - Each divergent sample increments mismatch_count (saturating), ORs sticky and resets the clean counter.
  - Each valid clean sample increments the clean counter; invalid samples leave it unchanged.
  - Clean counter reaching RECONV_CYCLES -> SETTLED, reconverged=1 for exactly one cycle.
- SETTLED: a divergent sample -> DIVERGED, counts as above; first_* stay unchanged.
- HALTED: all statistics frozen; only clear, arm or reset leave this state.
- Priority, highest first: reset_n, clear, arm, comparison.
- clear: everything as reset; stage 1 is also flushed.
- arm while not IDLE: zero statistics and enter ARMED in the same edge (clear+arm). A divergence pending in stage 1 that cycle is discarded.
- mismatch_count saturates at 2^CNT_W-1 and holds; the FSM keeps working normally.
- Changing channel_mask mid-run takes effect on the next stage-1 load; sticky bits already set are kept.
- NUM_CHANNELS=1: first_channel is 1 bit wide and always 0.

Decomposition:
- Package verinject_check_pkg holds:
  - the state enum/localparams (IDLE..HALTED);
  - a function for lowest-set-bit index;
  - a saturating-increment function.
- One sub-module, verinject_lane_compare: per-channel WIDTH compare with mask and a registered mismatch bit, instantiated NUM_CHANNELS times via generate.
- Count, capture and FSM logic stay in the top.

Test Plan:
1. Equal streams on both channels, arm at cycle 5, 100 valid samples -> state stays ARMED, mismatch_count=0, sticky=00, detect_latency=100.
2. Arm at cycle 10; inj channel 1 flipped at bit 3 for the single sample at cycle 30 -> mismatch_now=10 after edge 31, first_cycle=30, first_channel=1, detect_latency=20, mismatch_count=1.
3. Continue test 2 with 4 clean valid samples -> reconverged pulses once, state=SETTLED; a later divergent sample -> DIVERGED, mismatch_count=2, first_cycle still 30.
4. STOP_ON_FIRST=1, both channels mismatch at cycle 40 -> first_channel=0, halted=1, later mismatches leave mismatch_count=1.
5. channel_mask=01 with a mismatch only on channel 0 -> no divergence. clear and arm asserted in the same cycle -> IDLE with all statistics 0 (clear wins).
6. CNT_W=4, continuous mismatch for 20 samples -> mismatch_count holds at 15. reset_n=0 mid-run -> all outputs 0 after one edge.
